// File: rtl/snn_layer_seq.sv
// snn_layer_seq
// Sequencer for one fully-connected SNN layer. For each output neuron it
// clears the shared MAC, streams N_IN input/weight address pairs (one per
// cycle), waits two back-porch cycles for the memory read, MAC and LUT
// pipeline to settle, then writes the activated result to the destination
// RAM at the neuron index.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   start     begin a layer (sampled only while idle)
//   busy      high whenever the sequencer is not idle
//   done      one-cycle pulse after the last neuron is written
//   in_addr   input-unit RAM read address
//   wt_addr   weight ROM read address
//   mac_clr   synchronous MAC accumulator clear
//   mac_en    MAC accumulate enable (operands valid this cycle)
//   out_addr  destination RAM write address (= neuron index)
//   out_we    destination RAM write enable
module snn_layer_seq #(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 32,
    parameter int IN_AW  = 10,
    parameter int W_AW   = 15,
    parameter int OUT_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IN_AW-1:0]  in_addr,
    output logic [W_AW-1:0]   wt_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [OUT_AW-1:0] out_addr,
    output logic              out_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACCUM,
        S_BP1,
        S_BP2,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [IN_AW-1:0]  K_LAST = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0] N_LAST = OUT_AW'(N_OUT - 1);

    state_t state;
    state_t state_nxt;

    // in_addr doubles as the input counter k, out_addr as the neuron
    // counter n and wt_addr as the running weight counter w.

    always_comb begin
        state_nxt = state;
        mac_clr   = 1'b0;
        out_we    = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLR;
            S_CLR: begin
                mac_clr   = 1'b1;
                state_nxt = S_ACCUM;
            end
            S_ACCUM: if (in_addr == K_LAST) state_nxt = S_BP1;
            S_BP1:   state_nxt = S_BP2;
            S_BP2:   state_nxt = S_WRITE;
            S_WRITE: begin
                out_we    = 1'b1;
                state_nxt = (out_addr == N_LAST) ? S_DONE : S_CLR;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mac_en   <= 1'b0;
            in_addr  <= '0;
            wt_addr  <= '0;
            out_addr <= '0;
        end else begin
            state  <= state_nxt;
            // Operands reach the MAC one cycle after their addresses.
            mac_en <= (state == S_ACCUM);
            case (state)
                S_IDLE: if (start) out_addr <= '0;
                S_CLR: begin
                    in_addr <= '0;
                    // First neuron restarts the weight stream; later neurons
                    // continue from the held last address of the previous one.
                    wt_addr <= (out_addr == '0) ? '0 : wt_addr + 1'b1;
                end
                S_ACCUM: begin
                    if (state_nxt == S_ACCUM) begin
                        in_addr <= in_addr + 1'b1;
                        wt_addr <= wt_addr + 1'b1;
                    end
                end
                S_WRITE: if (out_addr != N_LAST) out_addr <= out_addr + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/snn_layer_seq.md
Name: snn_layer_seq

Overview:
- Sequencer for one fully-connected SNN layer built on the shared MAC, weight ROM, input RAM, activation LUT and destination RAM.
- On start, for each output neuron it:
  - clears the MAC;
  - streams input and weight addresses one per cycle;
  - drains the memory/MAC pipeline through two back-porch cycles;
  - writes the LUT-activated result to the destination RAM.
- One instance is used for the hidden layer (784→32) and one for the output layer (32→10).

Parameters:
- N_IN, 784, inputs per neuron (≥2)
- N_OUT, 32, neurons in layer (≥1)
- IN_AW, 10, input address width (2^IN_AW ≥ N_IN)
- W_AW, 15, weight address width (2^W_AW ≥ N_IN*N_OUT)
- OUT_AW, 5, destination address width (2^OUT_AW ≥ N_OUT)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high from the cycle after start acceptance until DONE inclusive
- done  out  1  one-cycle pulse when the last neuron is written
- in_addr  out  IN_AW  input-unit RAM read address
- wt_addr  out  W_AW  weight ROM read address
- mac_clr  out  1  synchronous MAC accumulator clear
- mac_en  out  1  MAC accumulate enable (operands valid this cycle)
- out_addr  out  OUT_AW  destination RAM write address (= neuron index)
- out_we  out  1  destination RAM write enable

Interface fixed: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (async, rst_n=0), all forced immediately:
  - state=IDLE;
  - all counters = 0;
  - in_addr=0, wt_addr=0, out_addr=0;
  - busy=0, done=0, mac_clr=0, mac_en=0, out_we=0.
- Memories (input RAM, weight ROM, LUT) have 1-cycle synchronous read. The MAC registers on the edge ending the cycle in which mac_en=1.
- States: IDLE, CLR, ACCUM, BP1, BP2, WRITE, DONE.
- IDLE:
  - start=1 → CLR, with neuron counter n=0 and weight counter w=0.
  - Otherwise stay in IDLE.
- CLR (1 cycle):
  - mac_clr=1; input counter k=0.
  - → ACCUM.
- ACCUM (N_IN cycles):
  - in_addr=k, wt_addr=w; both counters increment each cycle.
  - After k=N_IN-1 → BP1.
- mac_en:
  - Registered copy of "ACCUM this cycle", so it is high for exactly N_IN consecutive cycles.
  - Those cycles are the last N_IN-1 ACCUM cycles plus BP1.
- BP1 (1 cycle): last product accumulates → BP2.
- BP2 (1 cycle): accumulator final and feeding the LUT address → WRITE.
- WRITE (1 cycle):
  - out_we=1, out_addr=n.
  - If n=N_OUT-1 → DONE; else n++ → CLR.
- DONE (1 cycle): done=1 → IDLE.
- Address holding:
  - w is a running counter, never a multiply.
  - Neuron j uses weight addresses j*N_IN .. j*N_IN+N_IN-1.
  - The final address issued is N_IN*N_OUT-1, then w holds.
  - in_addr and wt_addr hold their last values outside ACCUM.
- Pulse rules:
  - mac_clr, out_we and done are single-cycle and mutually exclusive.
  - mac_en is never high in CLR, BP2 or WRITE.
- Latency:
  - Per neuron: N_IN+4 cycles (CLR + N_IN + BP1 + BP2 + WRITE).
  - Start acceptance to done pulse: N_OUT*(N_IN+4)+1 cycles.
- busy = (state ≠ IDLE).
- start while busy, including in DONE: ignored, with no restart or queuing.
- start held high continuously: a new layer starts on the cycle after DONE (IDLE sees start=1).
- Reset mid-layer: immediate return to IDLE. No out_we is issued, and the partial layer is discarded.
- The counter k wraps only by reload in CLR. No address exceeds N_IN-1 or N_IN*N_OUT-1.

Test Plan (N_IN=4, N_OUT=3, IN_AW=2, W_AW=4, OUT_AW=2 unless noted):
- Reset then idle 10 cycles → all outputs 0, busy=0, no pulses.
- start pulse at cycle 0 → timing per neuron:
  - mac_clr at cycles 1, 9, 17;
  - in_addr 0,1,2,3 at cycles 2-5;
  - wt_addr 0-3, 4-7, 8-11 for the three neurons;
  - mac_en high at cycles 3-6;
  - out_we with out_addr 0, 1, 2 at cycles 8, 16, 24;
  - done at cycle 25, busy low at cycle 26.
- MAC model (acc cleared by mac_clr, summing in*w on mac_en) with inputs=1 and weights=w_addr → written values: 6, 22, 38 (through an identity LUT).
- start re-asserted at cycles 5, 16 and 25 → ignored; exactly 3 writes and 1 done.
- rst_n low at cycle 12 (mid second neuron), released at cycle 14 → outputs 0 immediately, no further out_we; a fresh start then produces the full sequence from out_addr 0.
- Default parameters: one start → 32 writes, last wt_addr=25087, done 32*788+1=25217 cycles after start acceptance.
